// File: rtl/booth_div_seq.sv
// booth_div_seq: sequential signed divider, restoring radix-2, one quotient bit per clock.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module booth_div_seq #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          dbz,
  output logic          ovf
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(DW);
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dvd_q, dvd_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [VW-1:0]   rem_q, rem_d;
  logic [VW:0]     bm_q, bm_d;
  logic            sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, ov_q, ov_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic            dbz_q, dbz_d, ovf_q, ovf_d;
  logic [DW-1:0]   q_q, q_d;
  logic [VW-1:0]   r_q, r_d;
  logic [DW-1:0]   a_mag;
  logic [VW:0]     b_mag, shifted;
  logic            ge;
  logic [DW-1:0]   q_fix;
  logic [VW-1:0]   r_fix;
  // |a| fits DW unsigned bits: -2^(DW-1) negates to itself, read as unsigned.
  assign a_mag   = a[DW-1] ? -a : a;
  assign b_mag   = b[VW-1] ? -{b[VW-1], b} : {b[VW-1], b};
  assign shifted = {rem_q, dvd_q[DW-1]};
  assign ge      = shifted >= bm_q;
  assign q_fix   = (sa_q ^ sb_q) ? -quo_q : quo_q;
  assign r_fix   = sa_q ? -rem_q : rem_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    bm_d        = bm_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    dz_d        = dz_q;
    ov_d        = ov_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    q_d         = q_q;
    r_d         = r_q;
    case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        in_ready_d = 1'b0;
        dbz_d      = 1'b0;
        ovf_d      = 1'b0;
        sa_d       = a[DW-1];
        sb_d       = b[VW-1];
        bm_d       = b_mag;
        dvd_d      = a_mag;
        quo_d      = '0;
        rem_d      = '0;
        cnt_d      = '0;
        dz_d       = b == '0;
        ov_d       = (a == {1'b1, {(DW-1){1'b0}}}) && (b == '1);
        // Divide-by-zero skips the iteration and resolves in FIX.
        state_d    = (b == '0) ? FIX : CALC;
      end
      CALC: begin
        rem_d = ge ? VW'(shifted - bm_q) : shifted[VW-1:0];
        quo_d = {quo_q[DW-2:0], ge};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(DW-1)) ? FIX : CALC;
      end
      FIX: begin
        q_d         = dz_q ? '0 : ov_q ? {1'b1, {(DW-1){1'b0}}} : q_fix;
        r_d         = (dz_q || ov_q) ? '0 : r_fix;
        dbz_d       = dz_q;
        ovf_d       = ov_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      bm_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      bm_q        <= bm_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      q_q         <= q_d;
      r_q         <= r_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_booth_div_seq.sv
// tb_booth_div_seq: directed-vector bench for booth_div_seq with hand-computed results.
module tb_booth_div_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [7:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] q;
  logic [7:0]  r;
  logic        dbz;
  logic        ovf;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  booth_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .dbz(dbz), .ovf(ovf)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic start(input int av, input int bv);
    @(negedge clk);
    a = 16'(av);
    b = 8'(bv);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic check_res(input string name, input int eq, input int er, input int ed, input int eo);
    check({name, " q"}, $signed(q), eq);
    check({name, " r"}, $signed(r), er);
    check({name, " dbz"}, int'(dbz), ed);
    check({name, " ovf"}, int'(ovf), eo);
  endtask
  task automatic pop(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({name, " drop"}, int'(out_valid), 0);
    check({name, " ready"}, int'(in_ready), 1);
  endtask
  task automatic do_div(input string name, input int av, input int bv, input int eq, input int er,
                        input int ed, input int eo, input int elat);
    int lat;
    start(av, bv);
    wait_out(lat);
    check({name, " lat"}, lat, elat);
    check_res(name, eq, er, ed, eo);
    pop(name);
  endtask
  initial begin
    int lat;
    logic [15:0] q_hold;
    logic [7:0]  r_hold;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", int'(in_ready), 1);
    check("rst out_valid", int'(out_valid), 0);
    check_res("rst", 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle out_valid", int'(out_valid), 0);
    do_div("256/-16", 256, -16, -16, 0, 0, 0, 17);
    do_div("1000/7", 1000, 7, 142, 6, 0, 0, 17);
    do_div("-1000/7", -1000, 7, -142, -6, 0, 0, 17);
    do_div("1000/-7", 1000, -7, -142, 6, 0, 0, 17);
    do_div("-107/32", -107, 32, -3, -11, 0, 0, 17);
    do_div("min/-1", -32768, -1, -32768, 0, 0, 1, 17);
    do_div("min/1", -32768, 1, -32768, 0, 0, 0, 17);
    do_div("min/-128", -32768, -128, 256, 0, 0, 0, 17);
    do_div("32767/-128", 32767, -128, -255, 127, 0, 0, 17);
    do_div("7/0", 7, 0, 0, 0, 1, 0, 1);
    do_div("0/5", 0, 5, 0, 0, 0, 0, 17);
    do_div("-1/2", -1, 2, 0, -1, 0, 0, 17);
    // Backpressure window with an ignored in_valid pulse.
    start(-1000, -7);
    wait_out(lat);
    check("bp lat", lat, 17);
    check_res("bp", 142, -6, 0, 0);
    q_hold = q;
    r_hold = r;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      a = 16'd99;
      b = 8'd3;
      @(posedge clk);
      #1;
      check("bp valid", int'(out_valid), 1);
      check("bp in_ready", int'(in_ready), 0);
      check("bp q", int'(q), int'(q_hold));
      check("bp r", int'(r), int'(r_hold));
    end
    in_valid = 1'b0;
    pop("bp");
    repeat (20) @(posedge clk);
    #1 check("bp no queue", int'(out_valid), 0);
    // Asynchronous reset in mid-operation.
    start(1000, 7);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid in_ready", int'(in_ready), 1);
    check("mid out_valid", int'(out_valid), 0);
    check_res("mid", 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("mid no result", int'(out_valid), 0);
    do_div("60/12", 60, 12, 5, 0, 0, 0, 17);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
